// File: rtl/msrv_32_lsu.sv
// msrv_32_lsu: load/store unit for the MSRV32 core.
// Runs one data-memory access per start with req/ack handshake and timeout.
module msrv_32_lsu #(
    parameter int ACK_TIMEOUT = 16
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        start_in,
    input  logic        load_in,
    input  logic [2:0]  funct3_in,
    input  logic [31:0] addr_in,
    input  logic [31:0] store_data_in,
    output logic        busy_out,
    output logic        done_out,
    output logic [31:0] load_data_out,
    output logic        misaligned_out,
    output logic        err_out,
    output logic [31:0] dmem_addr_out,
    output logic        dmem_rd_req_out,
    output logic        dmem_wr_req_out,
    output logic [3:0]  dmem_wmask_out,
    output logic [31:0] dmem_wdata_out,
    input  logic [31:0] dmem_rdata_in,
    input  logic        dmem_ack_in,
    input  logic        dmem_err_in
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_next;

    logic [7:0]  r_cnt;
    logic [2:0]  r_f3;
    logic [1:0]  r_addr_lo;
    logic        r_load;

    logic        r_busy;
    logic        r_done;
    logic [31:0] r_ld;
    logic        r_mis;
    logic        r_err;
    logic [31:0] r_addr;
    logic        r_rd;
    logic        r_wr;
    logic [3:0]  r_mask;
    logic [31:0] r_wdata;

    logic [7:0]  w_cnt;
    logic        w_busy;
    logic        w_done;
    logic [31:0] w_ld;
    logic        w_mis;
    logic        w_err;
    logic [31:0] w_addr;
    logic        w_rd;
    logic        w_wr;
    logic [3:0]  w_mask;
    logic [31:0] w_wdata;

    logic        w_illegal;
    logic        w_timeout;
    logic [3:0]  w_st_mask;
    logic [31:0] w_st_wdata;
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [31:0] w_ext;

    assign busy_out        = r_busy;
    assign done_out        = r_done;
    assign load_data_out   = r_ld;
    assign misaligned_out  = r_mis;
    assign err_out         = r_err;
    assign dmem_addr_out   = r_addr;
    assign dmem_rd_req_out = r_rd;
    assign dmem_wr_req_out = r_wr;
    assign dmem_wmask_out  = r_mask;
    assign dmem_wdata_out  = r_wdata;

    assign w_timeout = (r_cnt == 8'(ACK_TIMEOUT - 1));

    always_comb begin
        w_illegal = 1'b1;
        case (funct3_in)
            3'b000:  w_illegal = 1'b0;
            3'b001:  w_illegal = addr_in[0];
            3'b010:  w_illegal = |addr_in[1:0];
            3'b100:  w_illegal = ~load_in;
            3'b101:  w_illegal = ~load_in | addr_in[0];
            default: w_illegal = 1'b1;
        endcase
    end

    always_comb begin
        w_st_mask  = 4'b0000;
        w_st_wdata = store_data_in;
        if (!load_in) begin
            case (funct3_in[1:0])
                2'b00: begin
                    w_st_mask  = 4'b0001 << addr_in[1:0];
                    w_st_wdata = {4{store_data_in[7:0]}};
                end
                2'b01: begin
                    w_st_mask  = 4'b0011 << {addr_in[1], 1'b0};
                    w_st_wdata = {2{store_data_in[15:0]}};
                end
                default: begin
                    w_st_mask  = 4'b1111;
                    w_st_wdata = store_data_in;
                end
            endcase
        end
    end

    assign w_byte = dmem_rdata_in[{r_addr_lo, 3'b000} +: 8];
    assign w_half = dmem_rdata_in[{r_addr_lo[1], 4'b0000} +: 16];

    always_comb begin
        w_ext = 32'd0;
        case (r_f3)
            3'b000:  w_ext = {{24{w_byte[7]}}, w_byte};
            3'b001:  w_ext = {{16{w_half[15]}}, w_half};
            3'b010:  w_ext = dmem_rdata_in;
            3'b100:  w_ext = {24'd0, w_byte};
            3'b101:  w_ext = {16'd0, w_half};
            default: w_ext = 32'd0;
        endcase
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_state   <= IDLE;
            r_cnt     <= 8'd0;
            r_f3      <= 3'd0;
            r_addr_lo <= 2'd0;
            r_load    <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_ld      <= 32'd0;
            r_mis     <= 1'b0;
            r_err     <= 1'b0;
            r_addr    <= 32'd0;
            r_rd      <= 1'b0;
            r_wr      <= 1'b0;
            r_mask    <= 4'd0;
            r_wdata   <= 32'd0;
        end else begin
            r_state <= w_next;
            r_cnt   <= w_cnt;
            r_busy  <= w_busy;
            r_done  <= w_done;
            r_ld    <= w_ld;
            r_mis   <= w_mis;
            r_err   <= w_err;
            r_addr  <= w_addr;
            r_rd    <= w_rd;
            r_wr    <= w_wr;
            r_mask  <= w_mask;
            r_wdata <= w_wdata;
            if (r_state == IDLE && start_in) begin
                r_f3      <= funct3_in;
                r_addr_lo <= addr_in[1:0];
                r_load    <= load_in;
            end
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (start_in) begin
                    w_next = w_illegal ? RESP : REQ;
                end
            end
            REQ: begin
                if (dmem_ack_in || w_timeout) begin
                    w_next = RESP;
                end
            end
            RESP:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Next values of the registered outputs; pulses default low.
    always_comb begin
        w_cnt   = r_cnt;
        w_busy  = (w_next != IDLE);
        w_done  = 1'b0;
        w_ld    = r_ld;
        w_mis   = 1'b0;
        w_err   = 1'b0;
        w_addr  = r_addr;
        w_rd    = 1'b0;
        w_wr    = 1'b0;
        w_mask  = r_mask;
        w_wdata = r_wdata;
        case (r_state)
            IDLE: begin
                if (start_in) begin
                    if (w_illegal) begin
                        w_done = 1'b1;
                        w_mis  = 1'b1;
                        if (load_in) begin
                            w_ld = 32'd0;
                        end
                    end else begin
                        w_cnt   = 8'd0;
                        w_addr  = {addr_in[31:2], 2'b00};
                        w_rd    = load_in;
                        w_wr    = ~load_in;
                        w_mask  = w_st_mask;
                        w_wdata = w_st_wdata;
                    end
                end
            end
            REQ: begin
                if (dmem_ack_in) begin
                    w_done = 1'b1;
                    w_err  = dmem_err_in;
                    if (r_load) begin
                        w_ld = dmem_err_in ? 32'd0 : w_ext;
                    end
                end else if (w_timeout) begin
                    w_done = 1'b1;
                    w_err  = 1'b1;
                    if (r_load) begin
                        w_ld = 32'd0;
                    end
                end else begin
                    w_cnt = r_cnt + 8'd1;
                    w_rd  = r_rd;
                    w_wr  = r_wr;
                end
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_msrv_32_lsu.sv
// tb_msrv_32_lsu: randomized and directed bench for msrv_32_lsu.
// A transaction-level model sets expected outputs; one process compares.
module tb_msrv_32_lsu;

    localparam int TO = 4;

    logic        clk;
    logic        rst;
    logic        start;
    logic        load;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] sdata;
    logic        busy;
    logic        done;
    logic [31:0] ldata;
    logic        mis;
    logic        err;
    logic [31:0] maddr;
    logic        rdreq;
    logic        wrreq;
    logic [3:0]  wmask;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        ack;
    logic        err_in;

    msrv_32_lsu #(.ACK_TIMEOUT(TO)) dut (
        .clk_in(clk),
        .rst_in(rst),
        .start_in(start),
        .load_in(load),
        .funct3_in(f3),
        .addr_in(addr),
        .store_data_in(sdata),
        .busy_out(busy),
        .done_out(done),
        .load_data_out(ldata),
        .misaligned_out(mis),
        .err_out(err),
        .dmem_addr_out(maddr),
        .dmem_rd_req_out(rdreq),
        .dmem_wr_req_out(wrreq),
        .dmem_wmask_out(wmask),
        .dmem_wdata_out(wdata),
        .dmem_rdata_in(rdata),
        .dmem_ack_in(ack),
        .dmem_err_in(err_in)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    bit          chk_en = 1'b0;
    bit          e_busy, e_done, e_mis, e_err, e_rd, e_wr, e_bus, e_wdchk;
    logic [31:0] e_ld, e_addr, e_wd;
    logic [3:0]  e_mask;
    logic [31:0] m_ld = 32'd0;

    logic [31:0] cap_addr, cap_wd;
    logic [3:0]  cap_mask;
    logic        cap_wr, cap_rd;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %h want %h", nm, $time, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("busy", 32'(busy), 32'(e_busy));
            chk("done", 32'(done), 32'(e_done));
            chk("misaligned", 32'(mis), 32'(e_mis));
            chk("err", 32'(err), 32'(e_err));
            chk("rd_req", 32'(rdreq), 32'(e_rd));
            chk("wr_req", 32'(wrreq), 32'(e_wr));
            chk("load_data", ldata, e_ld);
            if (e_bus) begin
                chk("dmem_addr", maddr, e_addr);
                chk("wmask", 32'(wmask), 32'(e_mask));
            end
            if (e_wdchk) begin
                chk("wdata", wdata, e_wd);
            end
        end
    end

    function automatic bit f_illegal(input bit ld, input int f, input int a);
        int sz;
        sz = f % 4;
        if (sz == 3 || f == 6) return 1'b1;
        if (f >= 4 && !ld) return 1'b1;
        return (a % (1 << sz)) != 0;
    endfunction

    function automatic logic [31:0] f_ext(input int f, input logic [31:0] a,
                                          input logic [31:0] rd);
        logic [31:0] b, h;
        int sh;
        sh = int'(a % 4);
        b = (rd >> (8 * sh)) & 32'hFF;
        h = (rd >> (16 * (sh / 2))) & 32'hFFFF;
        case (f)
            0: return (b >= 128) ? b + 32'hFFFFFF00 : b;
            1: return (h >= 32768) ? h + 32'hFFFF0000 : h;
            2: return rd;
            4: return b;
            5: return h;
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic [3:0] f_mask(input bit ld, input int f,
                                          input logic [31:0] a);
        int sh;
        sh = int'(a % 4);
        if (ld) return 4'd0;
        if (f == 0) return 4'(1 << sh);
        if (f == 1) return 4'(3 << ((sh / 2) * 2));
        return 4'd15;
    endfunction

    function automatic logic [31:0] f_wdata(input int f, input logic [31:0] d);
        if (f == 0) return (d & 32'hFF) * 32'h01010101;
        if (f == 1) return (d & 32'hFFFF) * 32'h00010001;
        return d;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_exp(input bit b, input bit d, input bit m,
                           input bit e, input bit r, input bit w);
        e_busy  = b;
        e_done  = d;
        e_mis   = m;
        e_err   = e;
        e_rd    = r;
        e_wr    = w;
        e_bus   = 1'b0;
        e_wdchk = 1'b0;
        e_ld    = m_ld;
    endtask

    // Caller is positioned #1 after an edge that left the DUT in IDLE.
    task automatic txn(input bit ld, input logic [2:0] f, input logic [31:0] a,
                       input logic [31:0] sd, input logic [31:0] rd,
                       input int dly, input bit er);
        bit fin, tmo;
        set_exp(0, 0, 0, 0, 0, 0);
        start  = 1'b1;
        load   = ld;
        f3     = f;
        addr   = a;
        sdata  = sd;
        ack    = 1'($urandom);
        err_in = 1'($urandom);
        rdata  = $urandom;
        tick();
        start = 1'($urandom);
        load  = 1'($urandom);
        f3    = 3'($urandom);
        addr  = $urandom;
        sdata = $urandom;
        if (f_illegal(ld, int'(f), int'(a))) begin
            if (ld) m_ld = 32'd0;
            set_exp(1, 1, 1, 0, 0, 0);
            ack    = 1'($urandom);
            err_in = 1'($urandom);
            tick();
        end else begin
            set_exp(1, 0, 0, 0, ld, !ld);
            e_bus   = 1'b1;
            e_addr  = a & 32'hFFFFFFFC;
            e_mask  = f_mask(ld, int'(f), a);
            e_wd    = f_wdata(int'(f), sd);
            e_wdchk = !ld;
            fin = 1'b0;
            tmo = 1'b0;
            for (int i = 0; !fin; i++) begin
                if (i == 0) begin
                    cap_addr = maddr;
                    cap_mask = wmask;
                    cap_wd   = wdata;
                    cap_wr   = wrreq;
                    cap_rd   = rdreq;
                end
                if (i == dly) begin
                    ack    = 1'b1;
                    err_in = er;
                    rdata  = rd;
                    fin    = 1'b1;
                end else begin
                    ack    = 1'b0;
                    err_in = 1'($urandom);
                    rdata  = $urandom;
                    if (i == TO - 1) begin
                        fin = 1'b1;
                        tmo = 1'b1;
                    end
                end
                tick();
            end
            if (ld) m_ld = (tmo || er) ? 32'd0 : f_ext(int'(f), a, rd);
            set_exp(1, 1, 0, tmo | er, 0, 0);
            ack    = 1'($urandom);
            err_in = 1'($urandom);
            rdata  = $urandom;
            tick();
        end
        start  = 1'b0;
        ack    = 1'b0;
        err_in = 1'b0;
        set_exp(0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        rst    = 1'b1;
        start  = 1'b0;
        load   = 1'b0;
        f3     = 3'd0;
        addr   = 32'd0;
        sdata  = 32'd0;
        rdata  = 32'd0;
        ack    = 1'b0;
        err_in = 1'b0;
        set_exp(0, 0, 0, 0, 0, 0);
        #2;
        chk("reset_outputs",
            {busy, done, mis, err, rdreq, wrreq, wmask} == 0 &&
            ldata == 0 && maddr == 0 && wdata == 0 ? 32'd1 : 32'd0, 32'd1);
        tick();
        tick();
        rst    = 1'b0;
        chk_en = 1'b1;

        txn(0, 3'b000, 32'h1003, 32'h000000A5, 32'h0, 2, 0);
        chk("sb_wr_req", 32'(cap_wr), 32'd1);
        chk("sb_addr", cap_addr, 32'h00001000);
        chk("sb_mask", 32'(cap_mask), 32'h8);
        chk("sb_wdata", cap_wd, 32'hA5A5A5A5);

        txn(1, 3'b000, 32'h2002, 32'h0, 32'h12F45678, 0, 0);
        chk("lb_data", ldata, 32'hFFFFFFF4);
        txn(1, 3'b100, 32'h2002, 32'h0, 32'h12F45678, 0, 0);
        chk("lbu_data", ldata, 32'h000000F4);
        txn(1, 3'b001, 32'h2002, 32'h0, 32'h8001ABCD, 0, 0);
        chk("lh_data", ldata, 32'hFFFF8001);
        txn(1, 3'b010, 32'h2000, 32'h0, 32'h8001ABCD, 1, 0);
        chk("lw_data", ldata, 32'h8001ABCD);
        txn(0, 3'b010, 32'h2004, 32'h11223344, 32'h0, 0, 1);
        chk("st_err_data_kept", ldata, 32'h8001ABCD);
        txn(1, 3'b010, 32'h3001, 32'h0, 32'h0, 0, 0);
        chk("lw_misaligned_data", ldata, 32'h0);
        chk("lw_misaligned_no_rd", 32'(cap_rd), 32'd0);
        txn(1, 3'b101, 32'h0042, 32'h0, 32'h9ABC7777, 0, 0);
        chk("lhu_data", ldata, 32'h00009ABC);
        txn(1, 3'b010, 32'h0040, 32'h0, 32'h0, 20, 0);
        chk("timeout_data", ldata, 32'h0);
        txn(0, 3'b001, 32'h0041, 32'h0, 32'h0, 0, 0);
        txn(0, 3'b101, 32'h0040, 32'h0, 32'h0, 0, 0);
        txn(1, 3'b011, 32'h0040, 32'h0, 32'h0, 0, 0);

        // Reset in the middle of a request.
        chk_en = 1'b0;
        start  = 1'b1;
        load   = 1'b1;
        f3     = 3'b010;
        addr   = 32'h0;
        tick();
        start = 1'b0;
        chk("pre_rst_rd_req", 32'(rdreq), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("rst_mid_req_outputs",
            {busy, done, mis, err, rdreq, wrreq} == 0 && ldata == 0 ?
            32'd1 : 32'd0, 32'd1);
        tick();
        rst    = 1'b0;
        m_ld   = 32'd0;
        set_exp(0, 0, 0, 0, 0, 0);
        chk_en = 1'b1;
        txn(1, 3'b010, 32'h0, 32'h0, 32'hCAFEF00D, 1, 0);
        chk("lw_after_rst", ldata, 32'hCAFEF00D);

        for (int k = 0; k < 300; k++) begin
            txn(1'($urandom), 3'($urandom), $urandom, $urandom, $urandom,
                int'($urandom_range(0, 5)), ($urandom % 6) == 0);
            if (($urandom % 4) == 0) tick();
        end
        tick();
        tick();
        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
